// File: rtl/csr_commit_pipe_pkg.sv
// Shared definitions for the CSR commit pipeline: exception codes, CSR field
// positions, the stage payload layouts and the tval selection rule.
package csr_commit_pipe_pkg;

   localparam int EXC_W = 6;
   typedef logic [EXC_W-1:0] exc_t;

   localparam exc_t EXC_NONE              = 6'h00;
   localparam exc_t EXC_ILLEGAL_INSTR     = 6'h12;
   localparam exc_t EXC_BREAKPOINT        = 6'h13;
   localparam exc_t EXC_LOAD_MISALIGNED   = 6'h14;
   localparam exc_t EXC_LOAD_FAULT        = 6'h15;
   localparam exc_t EXC_STORE_MISALIGNED  = 6'h16;
   localparam exc_t EXC_STORE_FAULT       = 6'h17;
   localparam exc_t EXC_INTERRUPT         = 6'h20;
   localparam exc_t EXC_FENCE             = 6'h30;
   localparam exc_t EXC_ERET              = 6'h31;

   localparam int CSR_ADDR_MSB = 31;
   localparam int CSR_ADDR_LSB = 20;
   localparam int CSR_ADDR_W   = CSR_ADDR_MSB - CSR_ADDR_LSB + 1;

   typedef struct packed {
      logic [31:0]           pc;
      logic [CSR_ADDR_W-1:0] csrAddr;
      logic [4:0]            rdIdx;
      logic [31:0]           value;
      logic                  write;
      logic [31:0]           wdata;
      exc_t                  exc;
   } e2_payload_t;

   typedef struct packed {
      logic [31:0]           pc;
      logic [CSR_ADDR_W-1:0] csrAddr;
      logic [4:0]            rdIdx;
      logic [31:0]           value;
      logic                  write;
      logic [31:0]           wdata;
      exc_t                  exc;
      logic [31:0]           tval;
   } wb_payload_t;

   // Illegal instructions report the opcode (carried in value), breakpoints the
   // PC, and memory faults the data address; everything else reports zero.
   function automatic logic [31:0] selectTval(input exc_t exc, input logic [31:0] value,
                                             input logic [31:0] pc, input logic [31:0] faultAddr);
      logic [31:0] tval;
      tval = '0;
      if (exc == EXC_ILLEGAL_INSTR) begin
         tval = value;
      end else if (exc == EXC_BREAKPOINT) begin
         tval = pc;
      end else if (exc == EXC_LOAD_MISALIGNED || exc == EXC_LOAD_FAULT ||
                   exc == EXC_STORE_MISALIGNED || exc == EXC_STORE_FAULT) begin
         tval = faultAddr;
      end
      return tval;
   endfunction

endpackage

// File: rtl/csr_commit_pipe_stage_reg.sv
// One pipeline stage: a valid bit plus an opaque payload, with hold and flush.
module csr_commit_stage_reg
   import csr_commit_pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   // A flush only kills the valid bit; the stale payload is harmless once invalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (!hold_i) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/csr_commit_pipe.sv
// E1 -> E2 -> WB commit pipeline for the CSR unit: merges memory faults and
// interrupts into one exception per instruction and drives the writeback bus.
module csr_commit_pipe
   import csr_commit_pipe_pkg::*;
#(
   parameter int SUPPORT_MEM_FAULT = 1,
   parameter int EXCEPTION_W       = EXC_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   e1_valid_i,
   input  logic [31:0]            e1_pc_i,
   input  logic [31:0]            e1_opcode_i,
   input  logic [4:0]             e1_rd_idx_i,
   input  logic [31:0]            csr_result_e1_value_i,
   input  logic                   csr_result_e1_write_i,
   input  logic [31:0]            csr_result_e1_wdata_i,
   input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
   input  logic [EXCEPTION_W-1:0] mem_fault_e2_i,
   input  logic [31:0]            mem_fault_addr_e2_i,
   input  logic                   take_interrupt_i,
   input  logic                   stall_i,
   output logic                   csr_writeback_write_o,
   output logic [11:0]            csr_writeback_waddr_o,
   output logic [31:0]            csr_writeback_wdata_o,
   output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
   output logic [31:0]            csr_writeback_exception_pc_o,
   output logic [31:0]            csr_writeback_exception_addr_o,
   output logic                   wb_rd_valid_o,
   output logic [4:0]             wb_rd_idx_o,
   output logic [31:0]            wb_rd_value_o,
   output logic                   flush_o
);

   e2_payload_t e2Payload_d, e2Payload_q;
   wb_payload_t wbPayload_d, wbPayload_q;
   logic        e2Valid_q, wbValid_q;
   exc_t        memFault, mergedExc, commitExc;
   logic [31:0] memFaultAddr;
   logic        takeIrq, commitActive, flush;
   logic        unusedOpcodeBits;

   // Only the CSR address field of the instruction word matters past E1.
   assign unusedOpcodeBits = ^e1_opcode_i[CSR_ADDR_LSB-1:0];

   assign e2Payload_d = '{pc:      e1_pc_i,
                          csrAddr: e1_opcode_i[CSR_ADDR_MSB:CSR_ADDR_LSB],
                          rdIdx:   e1_rd_idx_i,
                          value:   csr_result_e1_value_i,
                          write:   csr_result_e1_write_i,
                          wdata:   csr_result_e1_wdata_i,
                          exc:     csr_result_e1_exception_i};

   if (SUPPORT_MEM_FAULT != 0) begin : gMemFault
      assign memFault     = mem_fault_e2_i;
      assign memFaultAddr = mem_fault_addr_e2_i;
   end else begin : gNoMemFault
      logic unusedFaultInputs;
      assign unusedFaultInputs = ^{mem_fault_e2_i, mem_fault_addr_e2_i};
      assign memFault          = EXC_NONE;
      assign memFaultAddr      = '0;
   end

   // The E1 code is older information about the instruction, so it beats an LSU fault.
   assign mergedExc   = (e2Payload_q.exc != EXC_NONE) ? e2Payload_q.exc : memFault;
   assign wbPayload_d = '{pc:      e2Payload_q.pc,
                          csrAddr: e2Payload_q.csrAddr,
                          rdIdx:   e2Payload_q.rdIdx,
                          value:   e2Payload_q.value,
                          write:   e2Payload_q.write,
                          wdata:   e2Payload_q.wdata,
                          exc:     mergedExc,
                          tval:    selectTval(mergedExc, e2Payload_q.value,
                                              e2Payload_q.pc, memFaultAddr)};

   csr_commit_stage_reg #(.WIDTH($bits(e2_payload_t))) u_e2Stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hold_i  (stall_i),
      .flush_i (flush),
      .valid_i (e1_valid_i),
      .data_i  (e2Payload_d),
      .valid_o (e2Valid_q),
      .data_o  (e2Payload_q)
   );

   csr_commit_stage_reg #(.WIDTH($bits(wb_payload_t))) u_wbStage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .hold_i  (stall_i),
      .flush_i (flush),
      .valid_i (e2Valid_q),
      .data_i  (wbPayload_d),
      .valid_o (wbValid_q),
      .data_o  (wbPayload_q)
   );

   // Interrupts ride on a clean committing instruction; they never create a bubble commit.
   assign takeIrq      = wbValid_q && (wbPayload_q.exc == EXC_NONE) && take_interrupt_i;
   assign commitExc    = takeIrq ? EXC_INTERRUPT : wbPayload_q.exc;
   assign commitActive = wbValid_q && !stall_i;
   assign flush        = commitActive && (commitExc != EXC_NONE);

   assign csr_writeback_write_o          = commitActive && wbPayload_q.write && (commitExc == EXC_NONE);
   assign csr_writeback_waddr_o          = wbPayload_q.csrAddr;
   assign csr_writeback_wdata_o          = wbPayload_q.wdata;
   assign csr_writeback_exception_o      = commitActive ? commitExc : EXC_NONE;
   assign csr_writeback_exception_pc_o   = wbPayload_q.pc;
   assign csr_writeback_exception_addr_o = takeIrq ? 32'h0 : wbPayload_q.tval;
   assign wb_rd_valid_o                  = csr_writeback_write_o && (wbPayload_q.rdIdx != 5'd0);
   assign wb_rd_idx_o                    = wbPayload_q.rdIdx;
   assign wb_rd_value_o                  = wbPayload_q.value;
   assign flush_o                        = flush;

endmodule

// File: doc/csr_commit_pipe.md
Name: csr_commit_pipe

Overview:
- Carries CSR-unit E1 results and instruction context through E2 to the WB stage.
- Merges E2 memory faults and pending interrupts into a single exception per instruction.
- Drives the `csr_writeback_*` bus consumed by the CSR execute unit and its register file.
- Issues a pipeline flush when an exception commits, and squashes younger in-flight entries.

Parameters:
- SUPPORT_MEM_FAULT, 1, 1 = merge LSU fault inputs at E2; 0 = tie the fault path off.
- EXCEPTION_W, 6, exception code width, matching the shared definitions.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- e1_valid_i  in  1  instruction valid in E1
- e1_pc_i  in  32  E1 instruction PC
- e1_opcode_i  in  32  E1 instruction word
- e1_rd_idx_i  in  5  destination register
- csr_result_e1_value_i  in  32  CSR read value, or opcode on fault
- csr_result_e1_write_i  in  1  CSR write requested
- csr_result_e1_wdata_i  in  32  CSR write data
- csr_result_e1_exception_i  in  6  E1 exception code
- mem_fault_e2_i  in  6  LSU fault code for the E2 instruction
- mem_fault_addr_e2_i  in  32  faulting data address
- take_interrupt_i  in  1  registered interrupt request
- stall_i  in  1  hold all stages
- csr_writeback_write_o  out  1  CSR write strobe
- csr_writeback_waddr_o  out  12  CSR address (`opcode[31:20]`)
- csr_writeback_wdata_o  out  32  CSR write data
- csr_writeback_exception_o  out  6  committed exception code
- csr_writeback_exception_pc_o  out  32  PC of the faulting instruction
- csr_writeback_exception_addr_o  out  32  tval value
- wb_rd_valid_o  out  1  GPR write enable
- wb_rd_idx_o  out  5  GPR index
- wb_rd_value_o  out  32  GPR write data (CSR read value)
- flush_o  out  1  squash younger instructions

Behaviour:
- Reset: all stage valid bits and data registers are 0. All outputs are 0.
- Pipeline: two register stages, E2 and WB.
  - E1 data presented in cycle N appears on the WB outputs in cycle N+2, provided stall_i is low.
  - Each stage advances only when stall_i is 0. When stall_i is 1, both stages hold their contents.
- Strobe gating: `csr_writeback_write_o`, `csr_writeback_exception_o`, `wb_rd_valid_o` and `flush_o` are gated with `!stall_i`. Each WB entry therefore takes effect exactly once, in the first unstalled cycle.
- E2 capture: exception = E1 code if nonzero; else `mem_fault_e2_i`; else 0.
  - The E1 exception always wins over a memory fault.
  - The merged code is registered into WB.
- tval selection, captured into WB:
  - ILLEGAL_INSTRUCTION (6'h12): `value_i`, i.e. the opcode.
  - BREAKPOINT (6'h13): PC.
  - LOAD/STORE misaligned or fault (6'h14–6'h17): `mem_fault_addr_e2_i`.
  - All other codes: 0.
- Interrupt: if WB is valid with exception 0 and `take_interrupt_i` = 1, the commit becomes INTERRUPT (6'h20).
  - exception_pc = PC of that WB instruction.
  - The CSR write and the rd write are suppressed.
  - If WB is invalid, the interrupt waits; the block never generates a bubble commit.
- CSR write: `csr_writeback_write_o` = WB valid & write flag & committed exception == 0.
- rd write: `wb_rd_valid_o` = WB valid & write flag & committed exception == 0 & rd_idx ≠ 0.
- FENCE and ERET codes (≥ 6'h30) count as exceptions. The CSR write is suppressed for them, but they pass through unchanged.
- Flush: `flush_o` = WB valid & committed exception ≠ 0, unstalled.
  - In the same edge the E2 valid bit and the incoming E1 capture are cleared.
  - WB captures an invalid bubble.
- Back-to-back exceptions: the older one (in WB) commits. The younger one (in E2) is squashed and must never reach the outputs.
- Reset mid-operation clears all valid bits asynchronously. No partial write is emitted after rst_i deasserts.

Decomposition:
- Exception codes, CSR field ranges and `EXCEPTION_W` come from the shared definitions include. No local literals for exception codes.
- One sub-module, `csr_commit_stage_reg`: a valid + payload register with hold and flush inputs, instantiated for E2 and WB.
- Exception merge and tval select stay in the top level.

Test Plan:
- CSRRW to mscratch (0x340), wdata 0xDEADBEEF, rd = 5 → two cycles later: write = 1, waddr = 0x340, wdata = 0xDEADBEEF, rd_valid = 1, idx = 5, for exactly 1 cycle.
- E1 exception 6'h12, value 0x3402A073, pc 0x80000010 → exception_o = 0x12, pc = 0x80000010, addr = 0x3402A073, write = 0, flush_o = 1, next E2 instruction never commits.
- Clean E1 op, then `mem_fault_e2_i` = 6'h15 with addr 0x1003 → exception 0x15, addr 0x1003. Repeat with an E1 code of 6'h13 present → 0x13 wins, addr = PC.
- `take_interrupt_i` = 1 while WB holds a CSRRS instruction → exception 6'h20, CSR write and rd write suppressed, flush_o = 1.
- stall_i high for 3 cycles with a CSR write in WB → no strobe while stalled, then exactly one strobe after release, with data unchanged.
- rst_i asserted while E2 and WB are both valid → all outputs 0 immediately. No write or exception appears after reset release.
